// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_pkg
// Description : Shared constants for the dec_n_scan decoder family:
//               mode encodings, legal select-width range and the
//               per-edge operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dec_pkg;

  // Mode input encoding
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Legal select-width range
  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 6;

  // Operation selected on each rising edge
  localparam logic [1:0] OP_DECODE     = 2'd0;
  localparam logic [1:0] OP_SCAN_ENTRY = 2'd1;
  localparam logic [1:0] OP_SCAN_RUN   = 2'd2;
  localparam logic [1:0] OP_SCAN_PAUSE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
// Module      : dec_onehot
// Description : Combinational SEL_W-to-2^SEL_W one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_onehot #(
  parameter  int SEL_W = 2,
  localparam int OUTS  = 2**SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUTS-1:0]  onehot
);

  // One comparator per output bit; exactly one matches any select value
  for (genvar i = 0; i < OUTS; i++) begin : g_bit
    assign onehot[i] = (sel == SEL_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/dec_n_scan.sv
`default_nettype none
// ============================================================================
// Module      : dec_n_scan
// Description : Registered N-to-2^N one-hot decoder with enable and an
//               auto-scan mode that walks the strobe through every output,
//               holding each position for DWELL cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_n_scan
  import dec_pkg::*;
#(
  parameter  int SEL_W = 2,
  parameter  int DWELL = 4,
  localparam int OUTS  = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic             mode,
  input  logic [SEL_W-1:0] S,
  output logic [OUTS-1:0]  O,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int                DCNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] c_DCNT_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  c_IDX_LAST  = SEL_W'(OUTS - 1);

  // Reject illegal parameterisations at elaboration
  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX || DWELL < 1) begin : g_param_check
    $error("dec_n_scan: SEL_W must be %0d..%0d and DWELL >= 1", SEL_W_MIN, SEL_W_MAX);
  end

  logic [SEL_W-1:0]  r_idx;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_mode_q;
  logic [OUTS-1:0]   r_o;
  logic              r_wrap;

  logic [1:0]        w_op;
  logic [SEL_W-1:0]  w_idx_nxt;
  logic [DCNT_W-1:0] w_dcnt_nxt;
  logic              w_wrap_nxt;
  logic              w_o_en;
  logic [OUTS-1:0]   w_onehot;

  // The strobe always shows the index being loaded this edge
  dec_onehot #(.SEL_W(SEL_W)) u_onehot (
    .sel    (w_idx_nxt),
    .onehot (w_onehot)
  );

  // State register: async reset clears everything so restart is clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_dcnt   <= '0;
      r_mode_q <= MODE_DECODE;
      r_o      <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_mode_q <= mode;
      r_o      <= w_o_en ? w_onehot : '0;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // Operation select: scan entry is detected from the previous mode
  always_comb begin
    w_op = OP_DECODE;
    if (mode == MODE_SCAN) begin
      if (r_mode_q != MODE_SCAN) w_op = OP_SCAN_ENTRY;
      else if (E)                w_op = OP_SCAN_RUN;
      else                       w_op = OP_SCAN_PAUSE;
    end
  end

  // Next index / dwell / wrap / strobe-enable for the selected operation
  always_comb begin
    w_idx_nxt  = r_idx;
    w_dcnt_nxt = r_dcnt;
    w_wrap_nxt = 1'b0;
    w_o_en     = 1'b0;
    case (w_op)
      OP_DECODE, OP_SCAN_ENTRY: begin
        w_idx_nxt  = S;
        w_dcnt_nxt = '0;
        w_o_en     = E;
      end
      OP_SCAN_RUN: begin
        w_o_en = 1'b1;
        if (r_dcnt == c_DCNT_LAST) begin
          w_dcnt_nxt = '0;
          w_idx_nxt  = r_idx + SEL_W'(1);
          w_wrap_nxt = (r_idx == c_IDX_LAST);
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
      default: begin
        // Pause: index and dwell hold, strobe blanked
      end
    endcase
  end

  assign O    = r_o;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dec_n_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_n_scan
// Description : Self-checking bench for dec_n_scan. One instance with
//               SEL_W=2/DWELL=4, one with SEL_W=3/DWELL=1; expected
//               outputs are queued as stimulus is driven and popped after
//               each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_n_scan;
  import dec_pkg::*;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       a_E = 1'b0, a_mode = MODE_DECODE;
  logic [1:0] a_S = '0;
  logic [3:0] a_O;
  logic [1:0] a_idx;
  logic       a_wrap;

  logic       b_E = 1'b0, b_mode = MODE_DECODE;
  logic [2:0] b_S = '0;
  logic [7:0] b_O;
  logic [2:0] b_idx;
  logic       b_wrap;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_n_scan #(.SEL_W(2), .DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .E(a_E), .mode(a_mode), .S(a_S),
    .O(a_O), .idx(a_idx), .wrap(a_wrap)
  );

  dec_n_scan #(.SEL_W(3), .DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .E(b_E), .mode(b_mode), .S(b_S),
    .O(b_O), .idx(b_idx), .wrap(b_wrap)
  );

  function automatic exp_t mk(input int o, input int ix, input bit w);
    exp_t e;
    e.o    = 8'(o);
    e.idx  = 3'(ix);
    e.wrap = w;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_assert++;
    if ({a_O, a_idx, a_wrap} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_a: actual O=%h idx=%0d wrap=%b, required 0/0/0", a_O, a_idx, a_wrap);
    end
    n_assert++;
    if ({b_O, b_idx, b_wrap} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_b: actual O=%h idx=%0d wrap=%b, required 0/0/0", b_O, b_idx, b_wrap);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    exp_t e, g;
    a_mode = MODE_DECODE;
    for (int en = 1; en >= 0; en--) begin
      for (int s = 0; s < 4; s++) begin
        a_E = en[0];
        a_S = 2'(s);
        q_a.push_back(mk(en ? (1 << s) : 0, s, 1'b0));
        tick();
        e = q_a.pop_front();
        g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
        n_assert++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL decode[E=%0d S=%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                   en, s, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
        end
      end
    end
  endtask

  task automatic test_scan_pause();
    exp_t e, g;
    int   ix;
    // Decode at S=0 so the next mode=1 edge is a scan entry
    a_mode = MODE_DECODE; a_E = 1'b1; a_S = 2'd0;
    q_a.push_back(mk(1, 0, 1'b0));
    tick();
    void'(q_a.pop_front());
    a_mode = MODE_SCAN; a_S = 2'd2;
    // Entry plus twelve run edges: ends on the first cycle showing idx 1
    for (int k = 0; k <= 12; k++) begin
      ix = (2 + k / 4) % 4;
      q_a.push_back(mk(1 << ix, ix, (k > 0) && (k % 4 == 0) && (ix == 0)));
      tick();
      e = q_a.pop_front();
      g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scan[%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                 k, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
      end
      a_S = 2'($urandom_range(3, 0));   // must be ignored mid-scan
    end
    // Pause 3 edges, then the remaining 3 dwell cycles of idx 1, then idx 2, 3
    for (int k = 0; k < 12; k++) begin
      a_E = (k >= 3);
      if (k < 3)      q_a.push_back(mk(0, 1, 1'b0));
      else if (k < 6) q_a.push_back(mk(2, 1, 1'b0));
      else if (k < 10) q_a.push_back(mk(4, 2, 1'b0));
      else            q_a.push_back(mk(8, 3, 1'b0));
      tick();
      e = q_a.pop_front();
      g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pause[%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                 k, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
      end
      a_S = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic test_mode_toggle();
    exp_t e, g;
    a_E = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        a_mode = MODE_DECODE; a_S = 2'd1;
        q_a.push_back(mk(2, 1, 1'b0));
      end else if (k < 5) begin
        a_mode = MODE_SCAN;
        a_S = (k == 1) ? 2'd3 : 2'd0;
        q_a.push_back(mk(8, 3, 1'b0));
      end else begin
        q_a.push_back(mk(1, 0, k == 5));
      end
      tick();
      e = q_a.pop_front();
      g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL mode_toggle[%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                 k, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_corner_dwell1();
    exp_t e, g;
    int   ix;
    b_mode = MODE_DECODE; b_E = 1'b1; b_S = 3'd0;
    q_b.push_back(mk(1, 0, 1'b0));
    tick();
    void'(q_b.pop_front());
    b_mode = MODE_SCAN; b_S = 3'd6;
    for (int k = 0; k < 6; k++) begin
      ix = (6 + k) % 8;
      q_b.push_back(mk(1 << ix, ix, (k > 0) && (ix == 0)));
      tick();
      e = q_b.pop_front();
      g = {b_O, b_idx, b_wrap};
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL dwell1[%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                 k, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
      end
      b_S = 3'($urandom_range(7, 0));
    end
    b_mode = MODE_DECODE; b_E = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    a_mode = MODE_DECODE; a_E = 1'b1; a_S = 2'd2;
    q_a.push_back(mk(4, 2, 1'b0));
    tick();
    e = q_a.pop_front();
    g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
    n_assert++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_mid_pre: actual O=%h idx=%0d, required O=%h idx=%0d", g.o, g.idx, e.o, e.idx);
    end
    // Assert reset between edges: outputs must clear without a clock
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({a_O, a_idx, a_wrap} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_async: actual O=%h idx=%0d wrap=%b, required 0/0/0", a_O, a_idx, a_wrap);
    end
    a_mode = MODE_SCAN; a_S = 2'd3;
    tick();
    n_assert++;
    if ({a_O, a_idx, a_wrap} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_hold: actual O=%h idx=%0d wrap=%b, required 0/0/0", a_O, a_idx, a_wrap);
    end
    rst_n = 1'b1;
    // mode=1 after reset is a fresh scan entry at S
    for (int k = 0; k < 5; k++) begin
      if (k < 4) q_a.push_back(mk(8, 3, 1'b0));
      else       q_a.push_back(mk(1, 0, 1'b1));
      tick();
      e = q_a.pop_front();
      g = {4'b0, a_O, 1'b0, a_idx, a_wrap};
      n_assert++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_restart[%0d]: actual O=%h idx=%0d wrap=%b, required O=%h idx=%0d wrap=%b",
                 k, g.o, g.idx, g.wrap, e.o, e.idx, e.wrap);
      end
      a_S = 2'($urandom_range(3, 0));
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_scan_pause();
    test_mode_toggle();
    test_corner_dwell1();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
